// File: rtl/adder64_chk_pkg.sv
// Shared types and default geometry for the adder64 concurrent-error checker.
package adder64_chk_pkg;

   localparam int DEF_WIDTH = 64;
   localparam int DEF_SLICE = 16;

   typedef enum logic [1:0] {
      NORMAL   = 2'd0,
      DEGRADED = 2'd1,
      ALARM    = 2'd2
   } health_t;

endpackage

// File: rtl/adder64_chk_slice.sv
// One stage-1 reduction slice: dual-rail mismatch and local parity of the true sum.
module adder64_chk_slice #(
   parameter int SLICE = 16
) (
   input  logic [SLICE-1:0] s,
   input  logic [SLICE-1:0] s_inv,
   output logic             mismatch,
   output logic             parity
);

   // A healthy pair has s ^ s_inv all ones, so the XNOR term is zero everywhere.
   assign mismatch = |(s ^ s_inv ^ {SLICE{1'b1}});
   assign parity   = ^s;

endmodule

// File: rtl/adder64_fault_checker.sv
// Two-stage dual-rail/parity checker for the duplicated adder, with saturating
// error count and a NORMAL/DEGRADED/ALARM health FSM.
module adder64_fault_checker
   import adder64_chk_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int SLICE     = DEF_SLICE,
   parameter int THRESH    = 4,
   parameter int CLEAN_RUN = 8,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] s_inv,
   input  logic             p_pred,
   input  logic             clr,
   output logic             out_valid,
   output logic             dual_err,
   output logic             par_err,
   output logic [CNT_W-1:0] err_count,
   output logic [1:0]       health,
   output logic             alarm
);

   localparam int NSL    = WIDTH / SLICE;
   localparam int STAGES = 1;
   localparam int RUN_W  = $clog2(CLEAN_RUN + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);
   localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(CLEAN_RUN);

   logic [NSL-1:0]    mis_c, par_c, mis_q, par_q;
   logic              ppred_q;
   logic [STAGES:0]   vld_pipe;   // [0] stage-1 valid, [STAGES] result valid
   logic              dual_q, par_err_q;

   health_t           state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
   logic [RUN_W-1:0]  run, run_n, run_inc;
   logic              hit, clean;

   genvar k;
   generate
      for (k = 0; k < NSL; k++) begin : g_slice
         adder64_chk_slice #(.SLICE(SLICE)) u_slice (
            .s        (s[k*SLICE +: SLICE]),
            .s_inv    (s_inv[k*SLICE +: SLICE]),
            .mismatch (mis_c[k]),
            .parity   (par_c[k])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe  <= '0;
         mis_q     <= '0;
         par_q     <= '0;
         ppred_q   <= 1'b0;
         dual_q    <= 1'b0;
         par_err_q <= 1'b0;
      end else begin
         vld_pipe  <= {vld_pipe[STAGES-1:0], in_valid};
         mis_q     <= mis_c;
         par_q     <= par_c;
         ppred_q   <= p_pred;
         // Flags are masked here so invalid slots never look erroneous downstream.
         dual_q    <= vld_pipe[0] & (|mis_q);
         par_err_q <= vld_pipe[0] & ((^par_q) ^ ppred_q);
      end
   end

   assign out_valid = vld_pipe[STAGES];
   assign dual_err  = dual_q;
   assign par_err   = par_err_q;

   assign hit     = out_valid & (dual_q | par_err_q);
   assign clean   = out_valid & ~(dual_q | par_err_q);
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
   assign run_inc = (run == RUN_TGT) ? run : run + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= NORMAL;
         cnt   <= '0;
         run   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         run   <= run_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      run_n   = run;
      if (clr) begin
         // clr outranks a coincident error: it is neither counted nor escalates.
         state_n = NORMAL;
         cnt_n   = '0;
         run_n   = '0;
      end else if (hit) begin
         cnt_n = cnt_inc;
         run_n = '0;
         case (state)
            NORMAL:   state_n = (THRESH == 1) ? ALARM : DEGRADED;
            DEGRADED: if (cnt_inc >= THR) state_n = ALARM;
            default:  state_n = state;
         endcase
      end else if (clean) begin
         run_n = run_inc;
         if (state == DEGRADED && run_inc == RUN_TGT) state_n = NORMAL;
      end
   end

   assign err_count = cnt;
   assign health    = state;
   assign alarm     = (state == ALARM);

endmodule

// File: tb/tb_adder64_fault_checker.sv
// Directed bench for adder64_fault_checker: default instance plus a narrow-counter instance.
module tb_adder64_fault_checker;

   logic        clk = 1'b0;
   logic        rst, rst2, in_valid, p_pred, clr;
   logic [63:0] s, s_inv;

   logic        ov, de, pe, al;
   logic [15:0] ec;
   logic [1:0]  hl;
   logic        ov2, de2, pe2, al2;
   logic [1:0]  ec2;
   logic [1:0]  hl2;

   int total = 0;
   int bad   = 0;

   logic        v, p1;
   logic [63:0] a, b, sum;
   int          sent;

   localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] BADI  = 64'hFFFF_FFFF_FFFF_FFFE;

   always #5 clk = ~clk;

   adder64_fault_checker dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .s(s), .s_inv(s_inv),
      .p_pred(p_pred), .clr(clr), .out_valid(ov), .dual_err(de), .par_err(pe),
      .err_count(ec), .health(hl), .alarm(al)
   );

   adder64_fault_checker #(.CNT_W(2), .THRESH(3)) dut_s (
      .clk(clk), .rst(rst2), .in_valid(in_valid), .s(s), .s_inv(s_inv),
      .p_pred(p_pred), .clr(clr), .out_valid(ov2), .dual_err(de2), .par_err(pe2),
      .err_count(ec2), .health(hl2), .alarm(al2)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] sv, input logic [63:0] iv, input logic pp);
      in_valid = 1'b1;
      s        = sv;
      s_inv    = iv;
      p_pred   = pp;
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rst2 = 1'b1; in_valid = 1'b0; clr = 1'b0;
      s = '0; s_inv = ONES; p_pred = 1'b0;
      step(); step();
      chk("rst_ov", ov, 0);
      chk("rst_de", de, 0);
      chk("rst_pe", pe, 0);
      chk("rst_ec", ec, 0);
      chk("rst_hl", hl, 0);
      chk("rst_al", al, 0);
      rst = 1'b0; rst2 = 1'b0;
      step();

      // Correct sums with a random valid pattern; out_valid trails in_valid by two cycles.
      p1 = 1'b0; sent = 0;
      while (sent < 1000 || p1) begin
         v = (sent < 1000) && ($urandom_range(0, 3) != 0);
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         sum = a + b;
         in_valid = v; s = sum; s_inv = ~sum; p_pred = ^sum;
         step();
         chk("t1_ov", ov, p1);
         chk("t1_de", de, 0);
         chk("t1_pe", pe, 0);
         p1 = v;
         if (v) sent++;
      end
      in_valid = 1'b0;
      step();
      chk("t1_ec", ec, 0);
      chk("t1_hl", hl, 0);

      // Single dual-rail error in bit 0.
      do_clr();
      push(64'h0, BADI, 1'b0);
      step();
      chk("t2_ov", ov, 1);
      chk("t2_de", de, 1);
      chk("t2_pe", pe, 0);
      step();
      chk("t2_ec", ec, 1);
      chk("t2_hl", hl, 1);

      // Parity error, then recovery after exactly eight clean results.
      do_clr();
      push(64'h1, ~64'h1, 1'b0);
      step();
      chk("t3_de", de, 0);
      chk("t3_pe", pe, 1);
      step();
      chk("t3_hl", hl, 1);
      for (int i = 0; i < 8; i++) push(64'h0, ONES, 1'b0);
      step();
      chk("t3_hl7", hl, 1);
      step();
      chk("t3_hl8", hl, 0);
      chk("t3_ec", ec, 1);

      // Four back-to-back errors escalate to ALARM, which then stays sticky.
      do_clr();
      for (int i = 0; i < 4; i++) push(64'h0, BADI, 1'b0);
      chk("t4_ec2", ec, 2);
      chk("t4_hl2", hl, 1);
      step();
      chk("t4_ec3", ec, 3);
      chk("t4_hl3", hl, 1);
      step();
      chk("t4_ec4", ec, 4);
      chk("t4_hl4", hl, 2);
      chk("t4_al", al, 1);
      for (int i = 0; i < 20; i++) push(64'h0, ONES, 1'b0);
      step(); step(); step();
      chk("t4_sticky", hl, 2);
      chk("t4_ecs", ec, 4);
      do_clr();
      chk("t4_clr_hl", hl, 0);
      chk("t4_clr_ec", ec, 0);
      chk("t4_clr_al", al, 0);

      // clr lands on the same edge as an erroneous result.
      push(64'h0, BADI, 1'b0);
      step();
      chk("t5_ov", ov, 1);
      chk("t5_de", de, 1);
      do_clr();
      chk("t5_ec", ec, 0);
      chk("t5_hl", hl, 0);
      step();
      chk("t5_ec_b", ec, 0);
      chk("t5_hl_b", hl, 0);

      // Narrow counter saturates; THRESH 3 reaches ALARM.
      rst2 = 1'b1;
      step();
      rst2 = 1'b0;
      for (int i = 0; i < 6; i++) push(64'h0, BADI, 1'b0);
      step(); step(); step();
      chk("t6_ec_sat", ec2, 3);
      chk("t6_hl", hl2, 2);

      // Reset with samples in flight: nothing may emerge afterwards.
      push(64'h0, BADI, 1'b0);
      in_valid = 1'b1;
      rst2 = 1'b1;
      #1;
      chk("t6_rst_ov", ov2, 0);
      step();
      in_valid = 1'b0;
      rst2 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t6_post_ov", ov2, 0);
         chk("t6_post_de", de2, 0);
      end
      chk("t6_post_ec", ec2, 0);
      chk("t6_post_hl", hl2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adder64_fault_checker.md
# adder64_fault_checker

Pipelined concurrent-error checker on the output side of the 64-bit duplicated carry-select adder. Takes the true sum, inverted duplicate sum and predicted sum parity each cycle. Flags dual-rail mismatch and parity mismatch, counts errors and drives a health FSM that escalates to a sticky alarm. Sits between the adder datapath and the fault-reporting/status logic.

## Interface
- WIDTH, 64: sum width; must be a multiple of SLICE.
- SLICE, 16: reduction slice width in stage 1.
- THRESH, 4: error count that forces ALARM; range 1..2^CNT_W-1.
- CLEAN_RUN, 8: consecutive clean results that return DEGRADED to NORMAL.
- CNT_W, 16: error counter width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  s/s_inv/p_pred valid this cycle.
- s  in  WIDTH  sum from primary adder.
- s_inv  in  WIDTH  sum from duplicated adder, bitwise inverted.
- p_pred  in  1  predicted parity (XOR-reduction) of s.
- clr  in  1  synchronous clear of counter, run counter and FSM.
- out_valid  out  1  check result valid.
- dual_err  out  1  s != ~s_inv for that sample.
- par_err  out  1  ^s != p_pred for that sample.
- err_count  out  CNT_W  erroneous samples since reset/clr; saturating.
- health  out  2  FSM state: 0 NORMAL, 1 DEGRADED, 2 ALARM.
- alarm  out  1  health == ALARM.

## Operation
- Sample erroneous iff dual_err | par_err.
- Stage 1 (registered): per slice k, mismatch_k = |(s_k ^ s_inv_k ^ all-ones); parity_k = ^s_k. p_pred and valid registered alongside.
- Stage 2 (registered): dual_err = OR of mismatch_k; par_err = (XOR of parity_k) ^ p_pred; out_valid = stage-1 valid.
- Invalid samples: error flags forced 0 at output; no counter/FSM effect.
- err_count increments by 1 on each out_valid cycle with an error; holds at 2^CNT_W-1.
- Clean run counter: +1 on each clean out_valid result, zeroed on any error; width clog2(CLEAN_RUN+1).
- FSM:
  - NORMAL -> DEGRADED on an erroneous result.
  - DEGRADED -> ALARM when post-increment err_count >= THRESH.
  - DEGRADED -> NORMAL when the run counter reaches CLEAN_RUN. err_count not cleared.
  - ALARM sticky; left only by clr or rst.
  - THRESH = 1: first error goes NORMAL -> ALARM directly.
- clr: err_count, run counter 0; FSM NORMAL next cycle. Pipeline not flushed; dual_err/par_err of in-flight samples still reported.
- clr coincident with an erroneous result: clr wins; the error is not counted and does not move the FSM.

## Timing
- Latency 2: in_valid at edge N -> out_valid and flags at edge N+2. Full throughput, one sample per cycle, no backpressure.
- err_count, run counter, health and alarm update on the edge after the result is visible (N+3).
- Reset values: out_valid 0, dual_err 0, par_err 0, err_count 0, health NORMAL, alarm 0; pipeline valids 0.
- rst mid-stream drops in-flight samples; nothing reported for them.

## Structure
- Package adder64_chk_pkg: health_t enum (NORMAL, DEGRADED, ALARM), default WIDTH/SLICE constants.
- Sub-module adder64_chk_slice: one SLICE-wide stage-1 reduction (mismatch, parity). Instantiated WIDTH/SLICE times via generate.
- Top holds pipeline registers, counters and FSM.

## Test plan
- Reset, then 1000 random a+b sums with correct s_inv = ~s and correct p_pred -> dual_err = par_err = 0, err_count 0, health NORMAL, out_valid exactly 2 cycles after each in_valid.
- s = 64'h0, s_inv = 64'hFFFF_FFFF_FFFF_FFFE, p_pred = 0 -> dual_err 1, par_err 0, err_count 1, health DEGRADED.
- s = 64'h1, s_inv = ~64'h1, p_pred = 0 -> par_err 1, dual_err 0; followed by 8 clean samples -> health NORMAL, err_count stays 1.
- Four erroneous samples back-to-back (THRESH = 4) -> health DEGRADED after first, ALARM after fourth. 20 clean samples -> still ALARM. clr -> NORMAL, err_count 0.
- clr asserted in the same cycle an erroneous result has out_valid = 1 -> flag visible, err_count stays 0, health NORMAL.
- Force CNT_W = 2 with THRESH = 3; inject 6 errors -> err_count saturates at 3. Assert rst mid-stream with 2 samples in flight -> no out_valid after reset deasserts.
